// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronised start/clear buttons drive an IDLE/RUNNING/PAUSED FSM and a tick prescaler.
// Input debouncing is optional and built only when STOPWATCH_CTRL_DEBOUNCE_EN is defined.
module stopwatch_ctrl #(
   parameter int DIV             = 100000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_clear,
   output logic       start_resume,
   output logic       stop,
   output logic       clear,
   output logic       tick,
   output logic       running,
   output logic [1:0] dbg_state
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } state_t;

   localparam int            PW      = $clog2(DIV);
   localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

   if (DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("stopwatch_ctrl: DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   // Bit 1 is the clear button, bit 0 the start button.
   logic [1:0] w_btn;
   logic [1:0] w_filt;
   logic [1:0] w_press;
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] r_prev;
   logic [1:0] r_armed;
   logic [1:0] r_vld;

   assign w_btn = {btn_clear, btn_start};

   // A button is armed only after it has been seen released, so a level held through reset is not a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_vld   <= '0;
         r_prev  <= '0;
         r_armed <= '0;
      end else begin
         r_sync1 <= w_btn;
         r_sync2 <= r_sync1;
         r_vld   <= {r_vld[0], 1'b1};
         r_prev  <= w_filt;
         r_armed <= r_armed | ({2{r_vld[1]}} & ~r_sync2);
      end
   end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0][CW-1:0] r_db_cnt;
   logic [1:0]         r_filt;

   // The filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_db_cnt <= '0;
         r_filt   <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_filt[i]   <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign w_filt = r_filt;
`else
   assign w_filt = r_sync2;
`endif

   assign w_press = w_filt & ~r_prev & r_armed;

   state_t        r_state;
   state_t        w_next;
   logic          w_sr;
   logic          w_stop;
   logic          w_clr;
   logic          w_run_stay;
   logic [PW-1:0] r_presc;
   logic          r_start_resume;
   logic          r_stop;
   logic          r_clear;
   logic          r_tick;
   logic          r_running;

   always_comb begin
      w_next = r_state;
      w_sr   = 1'b0;
      w_stop = 1'b0;
      w_clr  = 1'b0;
      if (w_press[1]) begin
         w_next = IDLE;
         w_clr  = 1'b1;
      end else if (w_press[0]) begin
         case (r_state)
            RUNNING: begin
               w_next = PAUSED;
               w_stop = 1'b1;
            end
            default: begin
               w_next = RUNNING;
               w_sr   = 1'b1;
            end
         endcase
      end
   end

   assign w_run_stay = (r_state == RUNNING) && (w_next == RUNNING);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The prescaler advances only in cycles that stay RUNNING, so no tick coincides with a stop or clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc        <= '0;
         r_start_resume <= 1'b0;
         r_stop         <= 1'b0;
         r_clear        <= 1'b0;
         r_tick         <= 1'b0;
         r_running      <= 1'b0;
      end else begin
         r_start_resume <= w_sr;
         r_stop         <= w_stop;
         r_clear        <= w_clr;
         r_running      <= (w_next == RUNNING);
         r_tick         <= 1'b0;
         if (w_next == IDLE) begin
            r_presc <= '0;
         end else if (w_run_stay) begin
            if (r_presc == PS_LAST) begin
               r_presc <= '0;
               r_tick  <= 1'b1;
            end else begin
               r_presc <= r_presc + PW'(1);
            end
         end
      end
   end

   assign start_resume = r_start_resume;
   assign stop         = r_stop;
   assign clear        = r_clear;
   assign tick         = r_tick;
   assign running      = r_running;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DIV=4, DEBOUNCE_CYCLES=4; compile with or without
// STOPWATCH_CTRL_DEBOUNCE_EN to match the design build.
module tb_stopwatch_ctrl;
   localparam int DIV = 4;
   localparam int DB  = 4;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
   localparam int LAT = 3 + DB;
`else
   localparam int LAT = 3;
`endif
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic       clk;
   logic       reset;
   logic       btn_start;
   logic       btn_clear;
   logic       start_resume;
   logic       stop;
   logic       clear;
   logic       tick;
   logic       running;
   logic [1:0] dbg_state;
   logic [4:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   stopwatch_ctrl #(.DIV(DIV), .DEBOUNCE_CYCLES(DB)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .btn_start    (btn_start),
      .btn_clear    (btn_clear),
      .start_resume (start_resume),
      .stop         (stop),
      .clear        (clear),
      .tick         (tick),
      .running      (running),
      .dbg_state    (dbg_state)
   );

   assign obs = {start_resume, stop, clear, tick, running};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: expected {start_resume, stop, clear, tick, running} after each rising edge.
   logic [4:0] m_exp;
   int         m_mode;
   int         m_elapsed;
   bit         q_s[$];
   bit         q_c[$];
   bit         m_filt [2];
   bit         m_prev [2];
   bit         m_armed [2];
   int         m_run [2];

   always @(posedge clk or negedge reset) begin
      bit lvl [2];
      bit used [2];
      bit prs [2];
      if (!reset) begin
         q_s.delete();
         q_c.delete();
         for (int i = 0; i < 2; i++) begin
            m_filt[i]  = 1'b0;
            m_prev[i]  = 1'b0;
            m_armed[i] = 1'b0;
            m_run[i]   = 0;
         end
         m_mode    = M_IDLE;
         m_elapsed = 0;
         m_exp     = '0;
      end else begin
         q_s.push_back(btn_start);
         q_c.push_back(btn_clear);
         if (q_s.size() > 3) begin
            void'(q_s.pop_front());
            void'(q_c.pop_front());
         end
         lvl[0] = (q_s.size() == 3) ? q_s[0] : 1'b0;
         lvl[1] = (q_c.size() == 3) ? q_c[0] : 1'b0;
         for (int i = 0; i < 2; i++) begin
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
            used[i] = m_filt[i];
            if (lvl[i] != m_filt[i]) begin
               m_run[i]++;
               if (m_run[i] == DB) begin
                  m_filt[i] = lvl[i];
                  m_run[i]  = 0;
               end
            end else begin
               m_run[i] = 0;
            end
`else
            used[i] = lvl[i];
`endif
            prs[i]  = used[i] && !m_prev[i] && m_armed[i];
            m_prev[i] = used[i];
            if (q_s.size() == 3 && !lvl[i]) m_armed[i] = 1'b1;
         end
         m_exp = '0;
         if (prs[1]) begin
            m_mode    = M_IDLE;
            m_elapsed = 0;
            m_exp[2]  = 1'b1;
         end else if (prs[0]) begin
            if (m_mode == M_RUN) begin
               m_mode   = M_PAUSE;
               m_exp[3] = 1'b1;
            end else begin
               m_mode   = M_RUN;
               m_exp[4] = 1'b1;
            end
         end else if (m_mode == M_RUN) begin
            m_elapsed++;
            if (m_elapsed % DIV == 0) m_exp[1] = 1'b1;
         end
         m_exp[0] = (m_mode == M_RUN);
      end
   end

   task automatic test_reset();
      reset     = 1'b0;
      btn_start = 1'b0;
      btn_clear = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_hold: outputs got %b, required 00000", obs);
      end
      reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp || obs !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
      end
   endtask

   task automatic test_run();
      int p     = $urandom_range(2, 6);
      int t_sr  = -1;
      int n_sr  = 0;
      int t_run = -1;
      int ticks = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL run_cycle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
         if (start_resume) begin
            n_sr++;
            if (t_sr < 0) t_sr = c;
         end
         if (running && t_run < 0) t_run = c;
         if (t_run >= 0 && c > t_run && c <= t_run + 40 && tick) ticks++;
         if (c == p) btn_start = 1'b1;
         if (c == p + LAT + 3) btn_start = 1'b0;
      end
      n_checks++;
      if (n_sr !== 1 || t_sr !== p + LAT) begin
         n_fail++;
         $display("FAIL run_start_pulse: got %0d pulses at c=%0d, required 1 at c=%0d", n_sr, t_sr, p + LAT);
      end
      n_checks++;
      if (t_run !== p + LAT) begin
         n_fail++;
         $display("FAIL run_running_rise: got c=%0d, required c=%0d", t_run, p + LAT);
      end
      n_checks++;
      if (ticks !== 10) begin
         n_fail++;
         $display("FAIL run_tick_count: got %0d ticks in 40 cycles, required 10", ticks);
      end
   endtask

   task automatic test_pause();
      int skip    = $urandom_range(0, 3);
      int seen    = 0;
      int d       = -1;
      int t_stop  = -1;
      int ticks_p = 0;
      int t_sr    = -1;
      int t_tick  = -1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL pause_cycle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
         if (d >= 0) begin
            if (stop && t_stop < 0) t_stop = c;
            if (c >= d + LAT && c <= d + 20 + LAT && tick) ticks_p++;
            if (c > d + 20 && start_resume && t_sr < 0) t_sr = c;
            if (t_sr >= 0 && c > t_sr && tick && t_tick < 0) t_tick = c;
         end
         if (d < 0 && tick) begin
            if (seen == skip) begin
               d         = c;
               btn_start = 1'b1;
            end
            seen++;
         end else if (d >= 0 && c == d + LAT + 2) begin
            btn_start = 1'b0;
         end else if (d >= 0 && c == d + 20) begin
            btn_start = 1'b1;
         end else if (d >= 0 && c == d + 22 + LAT) begin
            btn_start = 1'b0;
         end
      end
      n_checks++;
      if (d < 0 || t_stop !== d + LAT) begin
         n_fail++;
         $display("FAIL pause_stop_pulse: got c=%0d, required c=%0d", t_stop, d + LAT);
      end
      n_checks++;
      if (ticks_p !== 0) begin
         n_fail++;
         $display("FAIL pause_no_tick: got %0d ticks while paused, required 0", ticks_p);
      end
      n_checks++;
      if (t_sr !== d + 20 + LAT) begin
         n_fail++;
         $display("FAIL pause_resume_pulse: got c=%0d, required c=%0d", t_sr, d + 20 + LAT);
      end
      n_checks++;
      if (t_tick !== t_sr + 2) begin
         n_fail++;
         $display("FAIL pause_first_tick: got c=%0d, required c=%0d", t_tick, t_sr + 2);
      end
   endtask

   task automatic test_simultaneous();
      int t0  = -1;
      int d   = -1;
      int bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL simul_cycle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
         if (d >= 0 && c == d + LAT) begin
            n_checks++;
            if (obs !== 5'b00100) begin
               n_fail++;
               $display("FAIL simul_clear_only: outputs got %b, required 00100", obs);
            end
         end
         if (d >= 0 && c > d + LAT && (tick || running)) bad++;
         if (d < 0 && tick) begin
            t0 = c;
         end else if (d < 0 && t0 >= 0 && c == t0 + 1) begin
            d         = c;
            btn_start = 1'b1;
            btn_clear = 1'b1;
         end else if (d >= 0 && c == d + LAT + 2) begin
            btn_start = 1'b0;
            btn_clear = 1'b0;
         end
      end
      n_checks++;
      if (d < 0 || bad !== 0) begin
         n_fail++;
         $display("FAIL simul_idle_quiet: got %0d active cycles (press at c=%0d), required 0", bad, d);
      end
   endtask

   task automatic test_clear_idle();
      int p = $urandom_range(2, 5);
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL clear_idle_cycle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
         if (c == p + LAT) begin
            n_checks++;
            if (obs !== 5'b00100) begin
               n_fail++;
               $display("FAIL clear_idle_pulse: outputs got %b, required 00100", obs);
            end
         end
         if (c == p) btn_clear = 1'b1;
         if (c == p + LAT + 2) btn_clear = 0;
      end
   endtask

   task automatic test_bounce();
      int n_sr    = 0;
      int n_stop  = 0;
      int t_first = -1;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
      int e_sr    = 1;
      int e_stop  = 0;
      int e_first = 20 + 3 + DB;
`else
      int e_sr    = 3;
      int e_stop  = 3;
      int e_first = 3;
`endif
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL bounce_cycle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
         if (start_resume) begin
            n_sr++;
            if (t_first < 0) t_first = c;
         end
         if (stop) n_stop++;
         btn_start = (c < 20) ? (((c / 2) % 2) == 0) : (c < 45);
      end
      n_checks++;
      if (n_sr !== e_sr || n_stop !== e_stop || t_first !== e_first) begin
         n_fail++;
         $display("FAIL bounce_pulses: got sr=%0d stop=%0d first=%0d, required sr=%0d stop=%0d first=%0d",
                  n_sr, n_stop, t_first, e_sr, e_stop, e_first);
      end
   endtask

   task automatic test_random();
      int seg = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL random_cycle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
         n_checks++;
         if (!$onehot0(obs[4:2])) begin
            n_fail++;
            $display("FAIL random_one_cmd c=%0d: commands got %b, required at most one high", c, obs[4:2]);
         end
         if (seg == 0) begin
            seg       = $urandom_range(1, 3 * LAT);
            btn_start = 1'($urandom_range(0, 1));
            btn_clear = ($urandom_range(0, 5) == 0);
         end
         seg--;
      end
   endtask

   task automatic test_reset_midrun();
      bit done  = 1'b0;
      int n_old = 0;
      int n_new = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL rst_setup_cycle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
         if (c == 0) begin
            btn_start = 1'b0;
            btn_clear = 1'b0;
         end
         if (c == LAT + 4) btn_clear = 1'b1;
         if (c == 2 * LAT + 6) btn_clear = 1'b0;
         if (c == 3 * LAT + 8) btn_start = 1'b1;
         if (c == 4 * LAT + 10) btn_start = 1'b0;
         if (c > 4 * LAT + 10 && m_mode == M_RUN && (m_elapsed % DIV) == 3) done = 1'b1;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL rst_setup_timeout: got no running cycle with prescaler 3, required one");
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (obs !== 5'b0) begin
         n_fail++;
         $display("FAIL rst_async_clear: outputs got %b, required 00000", obs);
      end
      btn_start = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs !== 5'b0) begin
         n_fail++;
         $display("FAIL rst_held_low: outputs got %b, required 00000", obs);
      end
      reset = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== m_exp) begin
            n_fail++;
            $display("FAIL rst_after_cycle c=%0d: outputs got %b, required %b", c, obs, m_exp);
         end
         if (start_resume && c < 30) n_old++;
         if (start_resume && c >= 30) n_new++;
         if (c == 30) btn_start = 1'b0;
         if (c == 33 + LAT) btn_start = 1'b1;
         if (c == 36 + 2 * LAT) btn_start = 1'b0;
      end
      n_checks++;
      if (n_old !== 0) begin
         n_fail++;
         $display("FAIL rst_held_button: got %0d start pulses, required 0", n_old);
      end
      n_checks++;
      if (n_new !== 1) begin
         n_fail++;
         $display("FAIL rst_new_press: got %0d start pulses, required 1", n_new);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_run();
      test_pause();
      test_simultaneous();
      test_clear_idle();
      test_bounce();
      test_random();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 100000: system clocks per tick period; legal range 2..2^24.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles needed to accept a button level; legal range 1..2^20.
REQ-003 Port clk  input  1: single system clock, all state on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port btn_start  input  1: raw start/stop pushbutton, asynchronous to clk, active-high.
REQ-006 Port btn_clear  input  1: raw clear pushbutton, asynchronous to clk, active-high.
REQ-007 Port start_resume  output  1: one-cycle pulse commanding the downstream counter chain to run.
REQ-008 Port stop  output  1: one-cycle pulse commanding the counter chain to hold.
REQ-009 Port clear  output  1: one-cycle pulse commanding the counter chain to zero.
REQ-010 Port tick  output  1: one-cycle count-enable pulse feeding the least-significant counter stage.
REQ-011 Port running  output  1: high while the FSM is in RUNNING.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A press SHALL be the rising edge of the filtered button level; it lasts one cycle regardless of how long the button is held.
REQ-014 FSM states: IDLE, RUNNING, PAUSED.
REQ-015 Transitions: IDLE+start→RUNNING; RUNNING+start→PAUSED; PAUSED+start→RUNNING; any state+clear→IDLE.
REQ-016 Clear press SHALL take priority over a start press in the same cycle; only clear is pulsed.
REQ-017 Clear in IDLE SHALL still pulse clear.
REQ-018 start_resume SHALL pulse on IDLE→RUNNING and PAUSED→RUNNING; stop SHALL pulse on RUNNING→PAUSED.
REQ-019 All outputs SHALL be registered; at most one of start_resume/stop/clear is high in any cycle.
REQ-020 Command pulses and running SHALL be high in the cycle after the press cycle.
REQ-021 Prescaler (ceil(log2 DIV) bits) SHALL increment only while running; it holds its value in PAUSED and is zeroed on entry to IDLE.
REQ-022 When the prescaler equals DIV-1 in RUNNING, tick SHALL pulse for one cycle and the prescaler wraps to 0; tick period is exactly DIV cycles.
REQ-023 Tick SHALL never be asserted outside RUNNING, including in the cycle a stop or clear pulse is issued.
REQ-024 A resume SHALL continue from the held prescaler value, so the first tick after resume arrives DIV minus the held count cycles later.

Reset
REQ-025 Reset low SHALL immediately force state IDLE, prescaler 0, synchronizers and filters 0, and all outputs 0.
REQ-026 Reset asserted mid-run SHALL discard any partial press or tick; no pulse is emitted on release.
REQ-027 Reset release SHALL be followed by normal operation; a button already held at release is not a press until it is released and pressed again.

Configuration
REQ-028 Macro STOPWATCH_CTRL_DEBOUNCE_EN defined: the filtered level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-029 Macro undefined: the filtered level equals the synchronized level, DEBOUNCE_CYCLES is ignored, and no debounce counter is built.
REQ-030 Latency with the macro undefined: from button high before rising edge 1, the output pulse is high after edge 3. With the macro defined: high after edge 3+DEBOUNCE_CYCLES.

Verification
REQ-031 The bench runs with DIV=4 and DEBOUNCE_CYCLES=4 and covers each case below.
REQ-032 Run case: reset, then a start press → one start_resume pulse, running=1, then tick every 4th cycle (10 ticks in 40 cycles).
REQ-033 Pause/resume case: press start two cycles after a tick → stop pulse and no further ticks. Press start again → start_resume pulse, and the next tick comes 2 cycles after running rises.
REQ-034 Simultaneous case: start and clear pressed in the same cycle while RUNNING → only clear pulses, state IDLE, running=0, and no tick in that cycle.
REQ-035 Bounce case: macro defined, start toggling every 2 cycles for 20 cycles, then held high → exactly one start_resume pulse, at stable+3+4 cycles. Macro undefined → one pulse per rising edge.
REQ-036 Reset case: reset asserted with prescaler=3 while running → all outputs 0 asynchronously. After release, start held through release produces no pulse.
